// File: rtl/mux_en_tx_ctrl.sv
// Source-side controller for the MUX-enable synchronizer: round-robin arbitration plus 4-phase en/ack handshake.
// Optional handshake timeout is enabled by defining MUXSYNC_TIMEOUT_EN.
module mux_en_tx_ctrl #(
   parameter int WIDTH   = 8,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64,
   localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk1,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data_in,
   input  logic                  ack_sync,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      data_out,
   output logic                  en_out,
   output logic [IW-1:0]         owner,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ASSERT  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             en_q, en_d;
   logic             err_q, err_d;

   logic             found;
   int               win;
   int               idx;
   logic             tmo;

`ifdef MUXSYNC_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter restarts on every state change, so each waiting phase gets its own budget.
   always_comb begin
      cnt_d = '0;
      if (state_d == state_q && (state_q == ASSERT || state_q == RELEASE))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk1) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tmo = (cnt_q == CW'(TIMEOUT - 1));
`else
   assign tmo = 1'b0;
`endif

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = 0;
      idx   = 0;
      for (int j = 0; j < NREQ; j++) begin
         idx = (int'(ptr_q) + j) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_d   = '0;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (found && !ack_sync) begin
               gnt_d[win] = 1'b1;
               data_d     = data_in[win*WIDTH +: WIDTH];
               owner_d    = IW'(win);
               ptr_d      = IW'((win + 1) % NREQ);
               state_d    = SETUP;
            end
         end
         SETUP:   state_d = ASSERT;
         ASSERT: begin
            if (ack_sync) begin
               state_d = RELEASE;
            end else if (tmo) begin
               state_d = RELEASE;
               err_d   = 1'b1;
            end
         end
         RELEASE: begin
            if (!ack_sync) begin
               state_d = IDLE;
            end else if (tmo) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      en_d = (state_d == ASSERT);
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         gnt_q   <= '0;
         data_q  <= '0;
         en_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         data_q  <= data_d;
         en_q    <= en_d;
         err_q   <= err_d;
      end
   end

   assign gnt      = gnt_q;
   assign data_out = data_q;
   assign en_out   = en_q;
   assign owner    = owner_q;
   assign busy     = (state_q != IDLE);
   assign err      = err_q;

endmodule
